// File: rtl/vc_read_cache_if.sv
// rtl/vc_read_cache_if.sv - split read/write memory handshake bundle shared by the cpu and bus sides of vc_read_cache
//
// Purpose: groups the raddr/rreq/rdata/rdone and waddr/wmask/wdata/wdone
// handshakes. The requester uses the master modport and the responder uses
// the slave modport.
// Signals:
//   raddr [PA-1:1]  read word address        (master -> slave)
//   rreq  [1:0]     read byte request        (master -> slave)
//   rdata [15:0]    read data                (slave -> master)
//   rdone           read-complete pulse      (slave -> master)
//   waddr [PA-1:1]  write word address       (master -> slave)
//   wmask [1:0]     write byte mask          (master -> slave)
//   wdata [15:0]    write data               (master -> slave)
//   wdone           write-complete pulse     (slave -> master)
interface vc_read_cache_if #(
    parameter int PA = 22
);
    logic [PA-1:1] raddr;
    logic [1:0]    rreq;
    logic [15:0]   rdata;
    logic          rdone;
    logic [PA-1:1] waddr;
    logic [1:0]    wmask;
    logic [15:0]   wdata;
    logic          wdone;

    modport master (
        output raddr, rreq, waddr, wmask, wdata,
        input  rdata, rdone, wdone
    );

    modport slave (
        input  raddr, rreq, waddr, wmask, wdata,
        output rdata, rdone, wdone
    );
endinterface

// File: rtl/vc_read_cache.sv
// rtl/vc_read_cache.sv - direct-mapped write-through read cache for 16-bit words
//
// Purpose: one-word lines held in flops. Read hits complete in one cycle.
// Read misses fill the line from the bus side. Writes always pass through to
// the bus and update the cached copy only when the tag matches, so there is
// no write-allocate.
// Ports:
//   clk       clock
//   reset_in  synchronous active-high reset; also aborts an open bus transaction
//   c         cpu side (slave modport of vc_read_cache_if)
//   m         bus-sequencer side (master modport of vc_read_cache_if)
//   hit_cnt   saturating read-hit count   (only with VC_CACHE_STATS_EN)
//   miss_cnt  saturating read-miss count  (only with VC_CACHE_STATS_EN)
// Optional feature macro: VC_CACHE_STATS_EN
module vc_read_cache #(
    parameter int PA     = 22,
    parameter int NLINES = 8
) (
    input  logic                    clk,
    input  logic                    reset_in,
    vc_read_cache_if.slave          c,
    vc_read_cache_if.master         m
`ifdef VC_CACHE_STATS_EN
    ,
    output logic [15:0]             hit_cnt,
    output logic [15:0]             miss_cnt
`endif
);
    localparam int L  = $clog2(NLINES);
    localparam int TW = PA - 1 - L;

    typedef enum logic [2:0] {IDLE, RDHIT, FILL, WRITE, DONE} state_t;

    state_t             state_q;
    logic [NLINES-1:0]  valid_q;
    logic [TW-1:0]      tag_q  [NLINES];
    logic [15:0]        data_q [NLINES];

    logic [15:0]        c_rdata_q;
    logic               c_rdone_q;
    logic               c_wdone_q;
    logic [PA-1:1]      m_raddr_q;
    logic [1:0]         m_rreq_q;
    logic [PA-1:1]      m_waddr_q;
    logic [1:0]         m_wmask_q;
    logic [15:0]        m_wdata_q;

    logic [L-1:0]       rd_idx, fill_idx, wr_idx;
    logic [TW-1:0]      rd_tag, fill_tag, wr_tag;
    logic               rd_hit, wr_hit;
    logic [15:0]        wr_merged_d;

    // Fill and write-update use the registered bus-side address, which stays
    // stable for the whole transaction.
    assign rd_idx   = c.raddr[L:1];
    assign rd_tag   = c.raddr[PA-1:L+1];
    assign fill_idx = m_raddr_q[L:1];
    assign fill_tag = m_raddr_q[PA-1:L+1];
    assign wr_idx   = m_waddr_q[L:1];
    assign wr_tag   = m_waddr_q[PA-1:L+1];

    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign wr_merged_d = {m_wmask_q[1] ? m_wdata_q[15:8] : data_q[wr_idx][15:8],
                          m_wmask_q[0] ? m_wdata_q[7:0]  : data_q[wr_idx][7:0]};

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            c_rdata_q <= '0;
            c_rdone_q <= 1'b0;
            c_wdone_q <= 1'b0;
            m_raddr_q <= '0;
            m_rreq_q  <= 2'b00;
            m_waddr_q <= '0;
            m_wmask_q <= 2'b00;
            m_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Writes win over a simultaneous read; the read stays
                    // pending and is sampled again after the write retires.
                    if (|c.wmask) begin
                        m_waddr_q <= c.waddr;
                        m_wmask_q <= c.wmask;
                        m_wdata_q <= c.wdata;
                        state_q   <= WRITE;
                    end else if (|c.rreq) begin
                        if (rd_hit) begin
                            c_rdata_q <= data_q[rd_idx];
                            c_rdone_q <= 1'b1;
                            state_q   <= RDHIT;
                        end else begin
                            m_raddr_q <= c.raddr;
                            m_rreq_q  <= 2'b11;
                            state_q   <= FILL;
                        end
                    end
                end
                RDHIT: begin
                    c_rdone_q <= 1'b0;
                    state_q   <= IDLE;
                end
                FILL: begin
                    if (m.rdone) begin
                        m_rreq_q          <= 2'b00;
                        valid_q[fill_idx] <= 1'b1;
                        c_rdata_q         <= m.rdata;
                        c_rdone_q         <= 1'b1;
                        state_q           <= DONE;
                    end
                end
                WRITE: begin
                    if (m.wdone) begin
                        m_wmask_q <= 2'b00;
                        c_wdone_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Turnaround cycle: the requester drops its request here.
                    c_rdone_q <= 1'b0;
                    c_wdone_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line payload has no reset; validity alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            if (state_q == FILL && m.rdone) begin
                tag_q[fill_idx]  <= fill_tag;
                data_q[fill_idx] <= m.rdata;
            end else if (state_q == WRITE && m.wdone && wr_hit) begin
                data_q[wr_idx] <= wr_merged_d;
            end
        end
    end

`ifdef VC_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        rd_accept;

    assign rd_accept = (state_q == IDLE) && !(|c.wmask) && (|c.rreq);

    always_ff @(posedge clk) begin
        if (reset_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rd_accept) begin
            if (rd_hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign c.rdata = c_rdata_q;
    assign c.rdone = c_rdone_q;
    assign c.wdone = c_wdone_q;
    assign m.raddr = m_raddr_q;
    assign m.rreq  = m_rreq_q;
    assign m.waddr = m_waddr_q;
    assign m.wmask = m_wmask_q;
    assign m.wdata = m_wdata_q;
endmodule
